// File: rtl/wb_i2c_pkg.sv
// Shared types and constants for the I2C engine scheduler and its requesters.
// State encoding, line-select codes and the engine's command bytes live here so
// requesters and the scheduler agree on them.
package wb_i2c_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

  // Engine bus select; LINES_NONE marks a no-op request that never enables the engine
  localparam logic [1:0] LINES_NONE = 2'd0;
  localparam logic [1:0] LINES_A    = 2'd1;
  localparam logic [1:0] LINES_B    = 2'd2;

  // Command bytes placed in the upper half of I2CDATA12
  localparam logic [7:0] I2C_CMD_A = 8'b11000000;
  localparam logic [7:0] I2C_CMD_B = 8'b11000010;

  // True when a window of 'cycles' is non-empty and its reload value fits cnt_w bits
  function automatic bit window_ok(input int cycles, input int cnt_w);
    return (cycles >= 1) && (longint'(cycles) <= (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/wb_i2c_sched_rr_arb.sv
// rr_arb: combinational round-robin arbiter. Picks the first set request at or
// after 'ptr', wrapping from N-1 back to 0, and returns both its index and a
// one-hot grant. Purely combinational so any shared-bus block can register the
// result in its own timing.
module rr_arb #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] winner,
  output logic [N-1:0]     grant
);

  logic [N-1:0]     req_rot;
  logic [PTR_W-1:0] offset;
  logic [PTR_W:0]   sum;

  // Rotate requests so that bit 0 corresponds to the pointer position
  assign req_rot = N'({req, req} >> ptr);

  // Lowest set bit of the rotated vector, mapped back to an absolute index
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment, so no path infers a latch.
    valid  = 1'b0;
    offset = '0;
    sum    = '0;
    winner = '0;
    grant  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        valid  = 1'b1;
        offset = PTR_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (PTR_W + 1)'(N)) begin
      sum = sum - (PTR_W + 1)'(N);
    end
    winner = sum[PTR_W-1:0];
    if (valid) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_i2c_sched.sv
// wb_i2c_sched: shares one 4-byte I2C engine between NREQ requesters.
// The engine has no done flag, so each transaction is a fixed sequence of
// windows: SETUP (data stable, enable low), SEND (enable high), GAP (enable low),
// with a one-cycle ack to the owner at the end of GAP.
// Build option: define WB_I2C_SCHED_PRIO_EN to give requester 0 fixed priority
// over the round-robin order; its grants leave the round-robin pointer alone.
module wb_i2c_sched
  import wb_i2c_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int SETUP_CYCLES = 16,
  parameter int SEND_CYCLES  = 12582912,
  parameter int GAP_CYCLES   = 4194304,
  parameter int CNT_W        = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [2*NREQ-1:0]    req_lines_i,
  input  logic [16*NREQ-1:0]   req_data12_i,
  input  logic [16*NREQ-1:0]   req_data34_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [NREQ-1:0]      grant_o,
  output logic                 busy_o,
  output logic                 i2c_enable_o,
  output logic [1:0]           i2c_lines_o,
  output logic [15:0]          i2c_data12_o,
  output logic [15:0]          i2c_data34_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SETUP = SETUP;
  localparam logic [1:0] ST_SEND  = SEND;
  localparam logic [1:0] ST_GAP   = GAP;

  // Window reload values: the counter runs from window-1 down to 0
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEND_LOAD  = CNT_W'(SEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  // Reject configurations that would give an empty or unrepresentable window
  if (!window_ok(SETUP_CYCLES, CNT_W) || !window_ok(SEND_CYCLES, CNT_W) ||
      !window_ok(GAP_CYCLES, CNT_W)) begin : g_bad_window
    $error("wb_i2c_sched: each window must be 1..2**CNT_W cycles");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("wb_i2c_sched: NREQ must be in 2..8");
  end

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] owner_q;
  logic [PTR_W-1:0] owner_next_ptr;
  logic             ptr_hold;

  logic             rr_valid;
  logic [PTR_W-1:0] rr_winner;
  logic [NREQ-1:0]  rr_grant;

  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  logic [NREQ-1:0]  win_oh;

  rr_arb #(
    .N (NREQ)
  ) u_rr_arb (
    .req    (req_i),
    .ptr    (rr_ptr_q),
    .valid  (rr_valid),
    .winner (rr_winner),
    .grant  (rr_grant)
  );

`ifdef WB_I2C_SCHED_PRIO_EN
  logic prio_q;

  // Requester 0 overrides the round-robin choice whenever it is asking
  always_comb begin
    win_valid = rr_valid;
    win_idx   = rr_winner;
    win_oh    = rr_grant;
    if (req_i[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
      win_oh    = NREQ'(1);
    end
  end

  // Remember whether the current transaction came from the priority path
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (state_q == ST_IDLE && win_valid) begin
      prio_q <= req_i[0];
    end
  end

  assign ptr_hold = prio_q;
`else
  assign win_valid = rr_valid;
  assign win_idx   = rr_winner;
  assign win_oh    = rr_grant;
  assign ptr_hold  = 1'b0;
`endif

  // Next round-robin start position: the slot just after the finishing owner
  assign owner_next_ptr = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  assign busy_o = (state_q != ST_IDLE);

  // Transaction sequencer: grant and latch, then time the setup/send/gap windows
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      ack_o        <= '0;
      grant_o      <= '0;
      i2c_enable_o <= 1'b0;
      i2c_lines_o  <= '0;
      i2c_data12_o <= '0;
      i2c_data34_o <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
      ack_o <= '0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_q      <= ST_SETUP;
            cnt_q        <= SETUP_LOAD;
            owner_q      <= win_idx;
            grant_o      <= win_oh;
            i2c_lines_o  <= req_lines_i[2*int'(win_idx) +: 2];
            i2c_data12_o <= req_data12_i[16*int'(win_idx) +: 16];
            i2c_data34_o <= req_data34_i[16*int'(win_idx) +: 16];
          end
        end

        ST_SETUP: begin
          if (cnt_q == '0) begin
            if (i2c_lines_o == LINES_NONE) begin
              state_q <= ST_GAP;
              cnt_q   <= GAP_LOAD;
            end else begin
              state_q      <= ST_SEND;
              cnt_q        <= SEND_LOAD;
              i2c_enable_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_SEND: begin
          if (cnt_q == '0) begin
            state_q      <= ST_GAP;
            cnt_q        <= GAP_LOAD;
            i2c_enable_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            ack_o   <= grant_o;
            grant_o <= '0;
            if (!ptr_hold) begin
              rr_ptr_q <= owner_next_ptr;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          grant_o      <= '0;
          i2c_enable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_i2c_sched.sv
// Self-checking bench for wb_i2c_sched with short windows (SETUP=4, SEND=10,
// GAP=3, NREQ=4). Each expected transaction is queued when its request is
// driven and checked (grant, latched data, enable window, ack timing) when the
// scheduler serves it.
module tb_wb_i2c_sched;
  import wb_i2c_pkg::*;

  localparam int NREQ  = 4;
  localparam int SETUP = 4;
  localparam int SEND  = 10;
  localparam int GAP   = 3;

  logic                 clk_i;
  logic                 rst_ni;
  logic [NREQ-1:0]      req_i;
  logic [2*NREQ-1:0]    req_lines_i;
  logic [16*NREQ-1:0]   req_data12_i;
  logic [16*NREQ-1:0]   req_data34_i;
  logic [NREQ-1:0]      ack_o;
  logic [NREQ-1:0]      grant_o;
  logic                 busy_o;
  logic                 i2c_enable_o;
  logic [1:0]           i2c_lines_o;
  logic [15:0]          i2c_data12_o;
  logic [15:0]          i2c_data34_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int              idx;
    logic [1:0]      lines;
    logic [15:0]     d12;
    logic [15:0]     d34;
    int              grant_lat;
    logic [NREQ-1:0] drop_mask;
  } txn_t;

  txn_t sb[$];

  wb_i2c_sched #(
    .NREQ         (NREQ),
    .SETUP_CYCLES (SETUP),
    .SEND_CYCLES  (SEND),
    .GAP_CYCLES   (GAP),
    .CNT_W        (24)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .req_lines_i  (req_lines_i),
    .req_data12_i (req_data12_i),
    .req_data34_i (req_data34_i),
    .ack_o        (ack_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .i2c_enable_o (i2c_enable_o),
    .i2c_lines_o  (i2c_lines_o),
    .i2c_data12_o (i2c_data12_o),
    .i2c_data34_o (i2c_data34_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [NREQ-1:0] oh(input int k);
    logic [NREQ-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int k, input logic [1:0] lines, input logic [15:0] d12,
                         input logic [15:0] d34);
    req_lines_i[2*k +: 2]   = lines;
    req_data12_i[16*k +: 16] = d12;
    req_data34_i[16*k +: 16] = d34;
  endtask

  // Queue the expected transaction for requester k from the stimulus it is being given
  task automatic expect_txn(input int k, input int lat, input logic [NREQ-1:0] mask);
    txn_t t;
    t.idx       = k;
    t.lines     = req_lines_i[2*k +: 2];
    t.d12       = req_data12_i[16*k +: 16];
    t.d34       = req_data34_i[16*k +: 16];
    t.grant_lat = lat;
    t.drop_mask = mask;
    sb.push_back(t);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // Serve n queued transactions: pop each at its grant and check it through its ack
  task automatic drain(input int n);
    txn_t t;
    int   w;
    int   c;
    int   en_cnt;
    int   en_first;
    int   exp_c;
    for (int k = 0; k < n; k++) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: got 0 queued entries, need 1 (txn %0d)", k);
        return;
      end
      t = sb.pop_front();
      w = 0;
      while (grant_o == '0 && w < 40) begin
        @(negedge clk_i);
        w++;
      end
      if (grant_o !== oh(t.idx)) begin
        n_fail++;
        $display("FAIL grant: got %b want %b (req %0d)", grant_o, oh(t.idx), t.idx);
        return;
      end
      n_tests++;
      if (t.grant_lat >= 0 && w != t.grant_lat) begin
        n_fail++;
        $display("FAIL grant_latency: got %0d want %0d (req %0d)", w, t.grant_lat, t.idx);
      end
      n_tests++;
      if ({i2c_lines_o, i2c_data12_o, i2c_data34_o} !== {t.lines, t.d12, t.d34}) begin
        n_fail++;
        $display("FAIL latch: got %h/%h/%h want %h/%h/%h (req %0d)", i2c_lines_o, i2c_data12_o,
                 i2c_data34_o, t.lines, t.d12, t.d34, t.idx);
      end
      n_tests++;
      if (busy_o !== 1'b1 || i2c_enable_o !== 1'b0) begin
        n_fail++;
        $display("FAIL grant_state: got busy=%b en=%b want busy=1 en=0", busy_o, i2c_enable_o);
      end
      c        = 0;
      en_cnt   = 0;
      en_first = -1;
      while (ack_o == '0 && c < 60) begin
        @(negedge clk_i);
        c++;
        if (i2c_enable_o === 1'b1) begin
          en_cnt++;
          if (en_first < 0) en_first = c;
        end
      end
      exp_c = SETUP + GAP + ((t.lines != LINES_NONE) ? SEND : 0);
      n_tests++;
      if (c != exp_c) begin
        n_fail++;
        $display("FAIL ack_latency: got %0d want %0d cycles after grant (req %0d)", c, exp_c, t.idx);
      end
      n_tests++;
      if (en_cnt != ((t.lines != LINES_NONE) ? SEND : 0)) begin
        n_fail++;
        $display("FAIL enable_width: got %0d want %0d (req %0d)", en_cnt,
                 (t.lines != LINES_NONE) ? SEND : 0, t.idx);
      end
      if (t.lines != LINES_NONE) begin
        n_tests++;
        if (en_first != SETUP) begin
          n_fail++;
          $display("FAIL enable_start: got %0d want %0d (req %0d)", en_first, SETUP, t.idx);
        end
      end
      n_tests++;
      if (ack_o !== oh(t.idx) || grant_o !== '0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_cycle: got ack=%b grant=%b busy=%b want ack=%b grant=0 busy=0",
                 ack_o, grant_o, busy_o, oh(t.idx));
      end
      n_tests++;
      if (i2c_data34_o !== t.d34 || i2c_lines_o !== t.lines) begin
        n_fail++;
        $display("FAIL hold: got %h/%h want %h/%h (req %0d)", i2c_lines_o, i2c_data34_o,
                 t.lines, t.d34, t.idx);
      end
      req_i = req_i & ~t.drop_mask;
      @(negedge clk_i);
      n_tests++;
      if (ack_o !== '0) begin
        n_fail++;
        $display("FAIL ack_pulse: got %b want 0 one cycle after ack", ack_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni       = 1'b0;
    req_i        = '0;
    req_lines_i  = '0;
    req_data12_i = '0;
    req_data34_i = '0;
    repeat (2) @(negedge clk_i);
    n_tests++;
    if ({ack_o, grant_o, busy_o, i2c_enable_o, i2c_lines_o, i2c_data12_o, i2c_data34_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b grant=%b busy=%b en=%b lines=%h d12=%h d34=%h want all 0",
               ack_o, grant_o, busy_o, i2c_enable_o, i2c_lines_o, i2c_data12_o, i2c_data34_o);
    end
    req_i = 4'b0001;
    repeat (2) @(negedge clk_i);
    n_tests++;
    if (grant_o !== '0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got grant=%b busy=%b want 0/0 while in reset", grant_o, busy_o);
    end
    req_i  = '0;
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, LINES_A, {I2C_CMD_A, 8'h40}, 16'h0640);
    expect_txn(0, 1, 4'b0001);
    req_i = 4'b0001;
    drain(1);
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, LINES_A, {I2C_CMD_A, 8'h01}, 16'h1111);
    set_req(1, LINES_B, {I2C_CMD_B, 8'h02}, 16'h2222);
    set_req(2, LINES_A, {I2C_CMD_A, 8'h03}, 16'h3333);
    set_req(3, LINES_B, {I2C_CMD_B, 8'h04}, 16'h4444);
    expect_txn(0, 1, 4'b0000);
    expect_txn(1, 0, 4'b0000);
    expect_txn(2, 0, 4'b0000);
    expect_txn(3, 0, 4'b0000);
    expect_txn(0, 0, 4'b1111);
    req_i = 4'b1111;
    drain(5);
  endtask

  task automatic test_noop();
    do_reset();
    set_req(2, LINES_NONE, {I2C_CMD_B, 8'hAA}, 16'h1234);
    expect_txn(2, 1, 4'b0100);
    req_i = 4'b0100;
    drain(1);
  endtask

  task automatic test_mid_change();
    do_reset();
    set_req(1, LINES_B, {I2C_CMD_B, 8'h10}, 16'h1900);
    expect_txn(1, 1, 4'b0010);
    req_i = 4'b0010;
    fork
      drain(1);
      begin
        repeat (8) @(negedge clk_i);
        set_req(1, LINES_B, {I2C_CMD_B, 8'h10}, 16'hFFF0);
      end
    join
    repeat (3) @(negedge clk_i);
    n_tests++;
    if (i2c_data34_o !== 16'h1900 || grant_o !== '0) begin
      n_fail++;
      $display("FAIL idle_hold: got d34=%h grant=%b want 1900/0", i2c_data34_o, grant_o);
    end
    expect_txn(1, 1, 4'b0010);
    req_i = 4'b0010;
    drain(1);
  endtask

  task automatic test_reset_abort();
    logic seen_ack;
    do_reset();
    set_req(2, LINES_A, {I2C_CMD_A, 8'h22}, 16'h0A0A);
    expect_txn(2, 1, 4'b0100);
    req_i = 4'b0100;
    drain(1);
    set_req(3, LINES_B, {I2C_CMD_B, 8'h33}, 16'h0B0B);
    set_req(1, LINES_A, {I2C_CMD_A, 8'h11}, 16'h0C0C);
    req_i = 4'b1000;
    @(negedge clk_i);
    n_tests++;
    if (grant_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_grant: got %b want 1000", grant_o);
    end
    req_i[1] = 1'b1;
    repeat (9) @(negedge clk_i);
    n_tests++;
    if (i2c_enable_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_send: got en=%b want 1 five cycles into send", i2c_enable_o);
    end
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (i2c_enable_o !== 1'b0 || grant_o !== '0 || busy_o !== 1'b0 || ack_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b grant=%b busy=%b ack=%b want all 0",
               i2c_enable_o, grant_o, busy_o, ack_o);
    end
    seen_ack = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      if (ack_o !== '0) seen_ack = 1'b1;
    end
    n_tests++;
    if (seen_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ack: got an ack during reset, want none");
    end
    expect_txn(1, 1, 4'b0010);
    expect_txn(3, 0, 4'b1000);
    rst_ni = 1'b1;
    drain(2);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, LINES_A, {I2C_CMD_A, 8'h50}, 16'h5000);
    set_req(1, LINES_B, {I2C_CMD_B, 8'h51}, 16'h5100);
    set_req(2, LINES_A, {I2C_CMD_A, 8'h52}, 16'h5200);
    set_req(3, LINES_B, {I2C_CMD_B, 8'h53}, 16'h5300);
    expect_txn(1, 1, 4'b0010);
    req_i = 4'b1110;
    fork
      drain(4);
      begin
        repeat (6) @(negedge clk_i);
        req_i[0] = 1'b1;
`ifdef WB_I2C_SCHED_PRIO_EN
        expect_txn(0, 0, 4'b0001);
        expect_txn(2, 0, 4'b0100);
        expect_txn(3, 0, 4'b1000);
`else
        expect_txn(2, 0, 4'b0100);
        expect_txn(3, 0, 4'b1000);
        expect_txn(0, 0, 4'b0001);
`endif
      end
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_noop();
    test_mid_change();
    test_reset_abort();
    test_back_to_back();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d unserved entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_i2c_sched.md
Name: wb_i2c_sched

Overview:
- Time-multiplexes the single 4-byte I2C engine (I2C4BYTES) between NREQ requesters, e.g. threshold DAC writer, HV ramp writer and an EEPROM/config writer.
- Replaces the fixed free-running looper. Round-robin arbitration with per-requester req/ack handshake.
- Drives the engine's ENABLE, I2CLINES, I2CDATA12 and I2CDATA34 inputs with fixed setup, enable and gap windows, because the engine has no done flag.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SETUP_CYCLES, 16, cycles data/lines are stable with enable low before the send.
- SEND_CYCLES, 12582912, cycles enable is held high (3 x 2^22, covers one 4-byte frame).
- GAP_CYCLES, 4194304, enable-low idle cycles after each send before the next grant.
- CNT_W, 24, width of the window counter; must hold max(SETUP, SEND, GAP).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NREQ  request per requester; level, held until ack.
- req_lines_i  in  2*NREQ  per-requester bus select; slice k is [2k+1:2k].
- req_data12_i  in  16*NREQ  per-requester address/command half-word.
- req_data34_i  in  16*NREQ  per-requester data half-word.
- ack_o  out  NREQ  one-cycle completion pulse for the granted requester.
- grant_o  out  NREQ  one-hot, current owner; all zero when idle.
- busy_o  out  1  high in any state other than IDLE.
- i2c_enable_o  out  1  engine ENABLE.
- i2c_lines_o  out  2  engine I2CLINES.
- i2c_data12_o  out  16  engine I2CDATA12.
- i2c_data34_o  out  16  engine I2CDATA34.

Behaviour:
- Reset (async on rst_ni low): state=IDLE, all outputs 0, round-robin pointer=0, counter=0. Reset mid-send drops enable immediately. No ack is issued for the aborted transaction.
- IDLE: if any req_i is set, select the winner and go to SETUP on the next edge. The winner is the first set bit at or after rr_ptr, wrapping at NREQ-1 -> 0.
  - On that edge, register the winner's lines/data12/data34 into the i2c_*_o outputs.
  - Set grant_o to the winner; set busy_o=1.
- SETUP: i2c_enable_o=0 for exactly SETUP_CYCLES cycles, then go to SEND.
  - If the latched lines==0, skip SEND and go to GAP; enable never rises (no-op request).
- SEND: i2c_enable_o=1 for exactly SEND_CYCLES cycles, then go to GAP with enable=0.
- GAP: enable=0 for GAP_CYCLES cycles.
  - On the last GAP cycle, pulse ack_o[winner] for one cycle.
  - Set rr_ptr = winner+1 (mod NREQ). Clear grant_o. Return to IDLE.
- Latency: a request accepted from IDLE reaches ack after 1+SETUP+SEND+GAP cycles (1+SETUP+GAP for a lines==0 request).
- Data and lines are latched once at grant. Requester input changes during the transaction are ignored.
- req_i dropped after grant: the transaction still completes and ack still pulses.
- req_i dropped before grant: that requester is not served.
- Requester holding req_i through its ack: it is re-eligible next IDLE but only wins after the other pending requesters (round-robin fairness). Back-to-back grants to the same requester happen only when no other request is pending.
- Minimum one IDLE cycle between transactions; grant_o is zero in that cycle.
- Outputs are registered; i2c_data*/lines hold their last value after the transaction ends.
- Counter counts down from window-1 to 0. Zero-length windows are illegal; guard with an elaboration-time check.

Optional Feature:
- WB_I2C_SCHED_PRIO_EN defined: requester 0 has fixed priority over round-robin whenever it is asserted in IDLE. rr_ptr is not updated by requester-0 grants.
- WB_I2C_SCHED_PRIO_EN undefined: pure round-robin for all requesters, including 0.

Decomposition:
- Package wb_i2c_pkg:
  - state enum (IDLE, SETUP, SEND, GAP);
  - line-select constants LINES_NONE=0, LINES_A=1, LINES_B=2;
  - I2C command byte constants 8'b11000000 and 8'b11000010.
- One sub-module, rr_arb: combinational round-robin winner and one-hot grant from req and pointer. Reused by other shared-bus blocks.

Test Plan:
- Settings for all scenarios: SETUP=4, SEND=10, GAP=3, NREQ=4.
- Single request: req_i=0001, lines=1, data12=16'hC040, data34=16'h0640.
  - Outputs are latched 1 cycle later.
  - enable is high for exactly 10 cycles, starting 4 cycles after the setup edge.
  - ack_o=0001 pulses at cycle 18 after the request.
- Contention: req_i=1111 held constantly. Grant order 0,1,2,3,0. Each ack is a single-cycle pulse; grant_o is zero for one cycle between transactions.
- No-op: requester 2 with lines=0. enable never rises; ack_o=0100 arrives 1+4+3 cycles after the request.
- Mid-transaction change: requester 1 changes data34 from 0x1900 to 0xFFF0 during SEND. Outputs keep 0x1900 until the next grant.
- Reset: rst_ni low 5 cycles into SEND.
  - enable drops with no clock edge; no ack is issued; grant_o=0.
  - After release, the pending req restarts from SETUP with rr_ptr=0.
- With WB_I2C_SCHED_PRIO_EN: req_i=1110 and requester 0 asserts during transaction 1. Next grant is requester 0, then 2, 3.
